gray_ptr_sync: RTL and testbench
================================

GRAY_PTR_SYNC -- requirements
Module: gray_ptr_sync

Interface
REQ-001 SHALL have parameter WIDTH, default 8, counter width per channel (legal 2..32).
REQ-002 SHALL have parameter STAGES, default 2, synchroniser flop depth (legal 2..4).
REQ-003 SHALL have parameter CHANNELS, default 1, number of independent counters (legal 1..8).
REQ-004 SHALL have one clock and a synchronous, active-low reset. Ports are named clk and rst_n.
REQ-005 SHALL have port clk  input  1  destination-domain clock, rising edge.
REQ-006 SHALL have port rst_n  input  1  synchronous active-low reset.
REQ-007 SHALL have port gray_in  input  CHANNELS*WIDTH  Gray-coded counters from a foreign domain, asynchronous to clk. Channel c occupies bits [c*WIDTH +: WIDTH].
REQ-008 SHALL have port err_clr  input  1  synchronous clear of all err_multi bits.
REQ-009 SHALL have port cnt_out  output  CHANNELS*WIDTH  synchronised binary counter per channel.
REQ-010 SHALL have port cnt_delta  output  CHANNELS*WIDTH  binary increment since the previous cnt_out value, mod 2^WIDTH.
REQ-011 SHALL have port cnt_vld  output  CHANNELS  one-cycle strobe: cnt_out of that channel changed this cycle.
REQ-012 SHALL have port err_multi  output  CHANNELS  sticky flag: more than one Gray bit changed between consecutive synchronised samples.

Function
REQ-013 SHALL pass each channel through STAGES flops clocked by clk. The first stage is the only flop that samples gray_in.
REQ-014 SHALL decode the last synchronised stage combinationally from Gray to binary: b[W-1]=g[W-1]; b[i]=g[i]^b[i+1].
REQ-015 SHALL register the decoded value into cnt_out. Latency is STAGES+1 rising edges from the first edge that samples a stable gray_in.
REQ-016 SHALL keep a previous-Gray register per channel, loaded from the last stage every cycle.
REQ-017 SHALL compute cnt_delta = decoded_new - cnt_out_old, modulo 2^WIDTH. It is registered in the same edge as cnt_out. Wrap from 2^WIDTH-1 to 0 yields delta 1.
REQ-018 SHALL assert cnt_vld for exactly one cycle, in the cycle cnt_out takes a new value. cnt_vld stays 0 when the value is unchanged. cnt_delta holds 0 when cnt_vld is 0.
REQ-019 SHALL set err_multi[c] when the Hamming distance between last-stage Gray and previous Gray exceeds 1. The sample is still accepted: cnt_out, cnt_delta and cnt_vld update normally.
REQ-020 SHALL keep err_multi set until err_clr is high or reset. If err_clr and a new error occur in the same cycle, set wins.
REQ-021 SHALL contain a warm-up counter of STAGES+1 cycles after reset release. During warm-up:
  - cnt_out tracks the decoded value;
  - cnt_vld=0 and cnt_delta=0;
  - err_multi is not updated.
REQ-022 SHALL treat channels independently. Simultaneous events on several channels each produce their own strobe and flag in the same cycle.

Reset
REQ-023 SHALL, when rst_n=0 at a rising edge, clear all of the following to 0:
  - synchroniser stages;
  - previous-Gray registers;
  - cnt_out, cnt_delta, cnt_vld and err_multi;
  - the warm-up counter.
REQ-024 SHALL apply reset mid-operation with the same result. Warm-up restarts on the first edge with rst_n=1.

Structure
REQ-025 SHALL take the following from shared package gray_sync_pkg:
  - gray2bin and bin2gray functions;
  - popcount-greater-than-one function;
  - parameter limit constants (WIDTH_MAX=32, STAGES_MIN=2, STAGES_MAX=4, CHANNELS_MAX=8).
REQ-026 SHALL implement one channel in sub-module gray_ptr_sync_ch. The top level generates CHANNELS instances and owns the shared warm-up counter.
REQ-027 SHALL contain no logic between gray_in and the first synchroniser flop.

Verification
REQ-028 SHALL cover reset: WIDTH=8, STAGES=2, gray_in=0x00 -> all outputs 0; no cnt_vld during warm-up; cnt_out=0.
REQ-029 SHALL cover increment: gray_in steps through the Gray codes of 0..5 one code per 4 clks -> cnt_out follows 1..5 at STAGES+1 edges after each change; each step gives cnt_vld=1 and cnt_delta=1; err_multi stays 0.
REQ-030 SHALL cover wrap-around: Gray(255)=0x80 followed by Gray(0)=0x00 -> cnt_out=0x00, cnt_delta=0x01, cnt_vld=1, err_multi=0.
REQ-031 SHALL cover multi-bit error and clear: Gray(3)=0x02 jumps to Gray(12)=0x0A... then to 0x0D (Gray of 9) -> cnt_out=9, err_multi=1 held. Pulsing err_clr clears it. err_clr coinciding with a new 2-bit jump leaves err_multi=1.
REQ-032 SHALL cover multi-channel and mid-operation reset: CHANNELS=4, STAGES=3, channels 0 and 2 change in the same cycle -> cnt_vld=4'b0101 in one cycle. rst_n=0 mid-stream -> all outputs 0 the next cycle, and warm-up of 4 cycles is observed.

Source files
------------

// File: rtl/gray_sync_pkg.sv
// Shared helpers for the Gray-pointer synchroniser: code conversions,
// multi-bit-change detection and the parameter limits.
package gray_sync_pkg;

    localparam int WIDTH_MAX    = 32;
    localparam int STAGES_MIN   = 2;
    localparam int STAGES_MAX   = 4;
    localparam int CHANNELS_MAX = 8;

    // Wide enough to count to STAGES_MAX+1
    localparam int WARM_W = 3;

    typedef logic [WIDTH_MAX-1:0] word_t;

    // Zero-extended inputs decode correctly: leading zero Gray bits give zero binary bits.
    function automatic word_t gray2bin(input word_t g);
        word_t b;
        b[WIDTH_MAX-1] = g[WIDTH_MAX-1];
        for (int i = WIDTH_MAX - 2; i >= 0; i--) begin
            b[i] = g[i] ^ b[i+1];
        end
        return b;
    endfunction

    function automatic word_t bin2gray(input word_t b);
        return b ^ (b >> 1);
    endfunction

    // True when more than one bit of x is set
    function automatic logic popcount_gt1(input word_t x);
        return (x & (x - word_t'(1))) != '0;
    endfunction

endpackage

// File: rtl/gray_ptr_sync_ch.sv
// One channel: synchroniser chain, Gray decode, delta/strobe generation
// and the sticky multi-bit-change flag.
module gray_ptr_sync_ch
    import gray_sync_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] gray_in,
    input  logic             warm,
    input  logic             err_clr,
    output logic [WIDTH-1:0] cnt_out,
    output logic [WIDTH-1:0] cnt_delta,
    output logic             cnt_vld,
    output logic             err_multi
);

    logic [WIDTH-1:0] sync_p [STAGES];
    logic [WIDTH-1:0] prev_gray;
    logic [WIDTH-1:0] decoded;
    logic [WIDTH-1:0] delta;
    logic             changed;
    logic             multi;

    always_comb begin
        decoded = WIDTH'(gray2bin(word_t'(sync_p[STAGES-1])));
        delta   = decoded - cnt_out;
        changed = decoded != cnt_out;
        multi   = popcount_gt1(word_t'(sync_p[STAGES-1] ^ prev_gray));
    end

    // sync_p[0] is the only flop fed from the foreign domain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_p[s] <= '0;
            end
            prev_gray <= '0;
            cnt_out   <= '0;
            cnt_delta <= '0;
            cnt_vld   <= 1'b0;
            err_multi <= 1'b0;
        end else begin
            sync_p[0] <= gray_in;
            for (int s = 1; s < STAGES; s++) begin
                sync_p[s] <= sync_p[s-1];
            end
            prev_gray <= sync_p[STAGES-1];
            cnt_out   <= decoded;
            cnt_vld   <= changed && !warm;
            cnt_delta <= (changed && !warm) ? delta : '0;
            // A new error outranks a clear arriving on the same edge
            if (!warm) begin
                if (multi) begin
                    err_multi <= 1'b1;
                end else if (err_clr) begin
                    err_multi <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/gray_ptr_sync.sv
// Multi-channel Gray-coded pointer synchroniser; owns the warm-up counter
// that masks strobes and errors while the chains fill after reset.
module gray_ptr_sync
    import gray_sync_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int STAGES   = 2,
    parameter int CHANNELS = 1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHANNELS*WIDTH-1:0] gray_in,
    input  logic                      err_clr,
    output logic [CHANNELS*WIDTH-1:0] cnt_out,
    output logic [CHANNELS*WIDTH-1:0] cnt_delta,
    output logic [CHANNELS-1:0]       cnt_vld,
    output logic [CHANNELS-1:0]       err_multi
);

    localparam logic [WARM_W-1:0] WARM_LEN = WARM_W'(STAGES + 1);

    if (WIDTH < 2 || WIDTH > WIDTH_MAX || STAGES < STAGES_MIN || STAGES > STAGES_MAX ||
        CHANNELS < 1 || CHANNELS > CHANNELS_MAX) begin : g_bad_param
        $error("gray_ptr_sync: parameter out of range");
    end

    logic [WARM_W-1:0] warm_cnt;
    logic              warm;

    // Edges seen with warm_cnt = 0..STAGES are the warm-up window
    assign warm = warm_cnt != WARM_LEN;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            warm_cnt <= '0;
        end else if (warm) begin
            warm_cnt <= warm_cnt + WARM_W'(1);
        end
    end

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        gray_ptr_sync_ch #(
            .WIDTH  (WIDTH),
            .STAGES (STAGES)
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .gray_in   (gray_in[c*WIDTH +: WIDTH]),
            .warm      (warm),
            .err_clr   (err_clr),
            .cnt_out   (cnt_out[c*WIDTH +: WIDTH]),
            .cnt_delta (cnt_delta[c*WIDTH +: WIDTH]),
            .cnt_vld   (cnt_vld[c]),
            .err_multi (err_multi[c])
        );
    end

endmodule

// File: tb/tb_gray_ptr_sync.sv
// Scoreboard bench: a single-channel STAGES=2 instance and a four-channel
// STAGES=3 instance, driven with directed Gray sequences.
module tb_gray_ptr_sync;

    typedef struct {
        logic [31:0] cnt;
        logic [31:0] delta;
        logic [3:0]  mask;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;

    logic        a_rst_n, a_clr;
    logic [7:0]  a_gray, a_cnt, a_delta;
    logic [0:0]  a_vld, a_err;

    logic        b_rst_n, b_clr;
    logic [31:0] b_gray, b_cnt, b_delta;
    logic [3:0]  b_vld, b_err;

    exp_t qa[$];
    exp_t qb[$];
    exp_t ea, eb;

    gray_ptr_sync #(.WIDTH(8), .STAGES(2), .CHANNELS(1)) dut_a (
        .clk       (clk),
        .rst_n     (a_rst_n),
        .gray_in   (a_gray),
        .err_clr   (a_clr),
        .cnt_out   (a_cnt),
        .cnt_delta (a_delta),
        .cnt_vld   (a_vld),
        .err_multi (a_err)
    );

    gray_ptr_sync #(.WIDTH(8), .STAGES(3), .CHANNELS(4)) dut_b (
        .clk       (clk),
        .rst_n     (b_rst_n),
        .gray_in   (b_gray),
        .err_clr   (b_clr),
        .cnt_out   (b_cnt),
        .cnt_delta (b_delta),
        .cnt_vld   (b_vld),
        .err_multi (b_err)
    );

    initial forever #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive channel A and record the strobe expected STAGES+1 edges later
    task automatic push_a(input logic [7:0] g, input logic [7:0] c, input logic [7:0] d);
        exp_t e;
        e.cnt = 32'(c); e.delta = 32'(d); e.mask = 4'b0001; e.cyc = cyc + 3;
        qa.push_back(e);
        a_gray = g;
    endtask

    task automatic push_b(input logic [31:0] g, input logic [3:0] m,
                          input logic [31:0] c, input logic [31:0] d);
        exp_t e;
        e.cnt = c; e.delta = d; e.mask = m; e.cyc = cyc + 4;
        qb.push_back(e);
        b_gray = g;
    endtask

    always @(negedge clk) begin
        if (a_vld[0]) begin
            if (qa.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL a_unexpected_vld: got cnt_out %0h, expected no strobe", a_cnt);
            end else begin
                ea = qa.pop_front();
                check("a_cnt_out", 32'(a_cnt), ea.cnt);
                check("a_cnt_delta", 32'(a_delta), ea.delta);
                check("a_latency", cyc, ea.cyc);
            end
        end else begin
            check("a_idle_delta", 32'(a_delta), 32'h0);
        end
    end

    always @(negedge clk) begin
        if (b_vld != 4'b0000) begin
            if (qb.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL b_unexpected_vld: got cnt_vld %0b, expected none", b_vld);
            end else begin
                eb = qb.pop_front();
                check("b_cnt_vld", 32'(b_vld), 32'(eb.mask));
                check("b_cnt_out", b_cnt, eb.cnt);
                check("b_cnt_delta", b_delta, eb.delta);
                check("b_latency", cyc, eb.cyc);
            end
        end else begin
            check("b_idle_delta", b_delta, 32'h0);
        end
    end

    initial begin
        a_rst_n = 1'b0; a_clr = 1'b0; a_gray = 8'h00;
        b_rst_n = 1'b0; b_clr = 1'b0; b_gray = 32'h0000_0001;
        tick(3);

        // Channel A: reset state, then warm-up with a stable zero input
        check("a_rst_cnt", 32'(a_cnt), 32'h0);
        check("a_rst_vld", 32'(a_vld), 32'h0);
        check("a_rst_err", 32'(a_err), 32'h0);
        a_rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("a_warm_vld", 32'(a_vld), 32'h0);
            check("a_warm_cnt", 32'(a_cnt), 32'h0);
        end

        // Gray codes of 1..5, then back down to 3
        push_a(8'h01, 8'd1, 8'h01); tick(4);
        push_a(8'h03, 8'd2, 8'h01); tick(4);
        push_a(8'h02, 8'd3, 8'h01); tick(4);
        push_a(8'h06, 8'd4, 8'h01); tick(4);
        push_a(8'h07, 8'd5, 8'h01); tick(4);
        check("a_err_after_inc", 32'(a_err), 32'h0);
        push_a(8'h06, 8'd4, 8'hFF); tick(4);
        push_a(8'h02, 8'd3, 8'hFF); tick(4);

        // 3 -> 12 is a single Gray bit; 12 -> 9 flips three bits
        push_a(8'h0A, 8'd12, 8'h09); tick(4);
        check("a_err_single_bit", 32'(a_err), 32'h0);
        push_a(8'h0D, 8'd9, 8'hFD); tick(4);
        check("a_err_set", 32'(a_err), 32'h1);
        tick(3);
        check("a_err_held", 32'(a_err), 32'h1);
        a_clr = 1'b1; tick(1); a_clr = 1'b0;
        check("a_err_cleared", 32'(a_err), 32'h0);

        // Two-bit jump 9 -> 11 landing on the same edge as err_clr
        push_a(8'h0E, 8'd11, 8'h02);
        tick(2);
        a_clr = 1'b1; tick(1); a_clr = 1'b0;
        check("a_err_set_wins", 32'(a_err), 32'h1);
        tick(1);
        a_clr = 1'b1; tick(1); a_clr = 1'b0;
        check("a_err_cleared2", 32'(a_err), 32'h0);

        // Walk down to 0, then 255 and wrap back to 0
        for (int v = 10; v >= 0; v--) begin
            logic [7:0] bv;
            bv = 8'(v);
            push_a(bv ^ (bv >> 1), bv, 8'hFF);
            tick(4);
        end
        push_a(8'h80, 8'hFF, 8'hFF); tick(4);
        push_a(8'h00, 8'h00, 8'h01); tick(4);
        check("a_wrap_cnt", 32'(a_cnt), 32'h0);
        check("a_wrap_err", 32'(a_err), 32'h0);

        // Channel B: held in reset so far with ch0 already at Gray(1)
        check("b_rst_cnt", b_cnt, 32'h0);
        check("b_rst_vld", 32'(b_vld), 32'h0);
        check("b_rst_err", 32'(b_err), 32'h0);
        b_rst_n = 1'b1;
        tick(3);
        check("b_warm_cnt_early", b_cnt, 32'h0);
        tick(1);
        check("b_warm_cnt_tracks", b_cnt, 32'h0000_0001);
        check("b_warm_no_vld", 32'(b_vld), 32'h0);
        tick(2);

        push_b(32'h0001_0003, 4'b0101, 32'h0001_0002, 32'h0001_0001); tick(6);
        push_b(32'h0101_0103, 4'b1010, 32'h0101_0102, 32'h0100_0100); tick(6);
        push_b(32'h0101_0302, 4'b0011, 32'h0101_0203, 32'h0000_0101); tick(6);
        check("b_err_clean", 32'(b_err), 32'h0);

        // Mid-stream reset; ch1 and ch2 reappear as multi-bit jumps from zero
        b_rst_n = 1'b0;
        b_gray  = 32'h0107_0302;
        tick(1);
        check("b_mid_rst_cnt", b_cnt, 32'h0);
        check("b_mid_rst_delta", b_delta, 32'h0);
        check("b_mid_rst_vld", 32'(b_vld), 32'h0);
        check("b_mid_rst_err", 32'(b_err), 32'h0);
        tick(1);
        b_rst_n = 1'b1;
        tick(3);
        check("b_rewarm_cnt_early", b_cnt, 32'h0);
        tick(1);
        check("b_rewarm_cnt", b_cnt, 32'h0105_0203);
        check("b_rewarm_no_vld", 32'(b_vld), 32'h0);
        tick(1);
        check("b_rewarm_no_err", 32'(b_err), 32'h0);

        push_b(32'h0106_0302, 4'b0100, 32'h0104_0203, 32'h00FF_0000); tick(6);
        check("b_final_err", 32'(b_err), 32'h0);

        tick(2);
        check("a_queue_drained", 32'(qa.size()), 32'h0);
        check("b_queue_drained", 32'(qb.size()), 32'h0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
